wb_fpga_config_loader: RTL and testbench

//  Wishbone slave on the Caravel management bus that streams FPGA bitstream words from the

---
 rtl/wb_fpga_config_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_wb_fpga_config_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fpga_config_loader.sv
// Wishbone slave that buffers FPGA bitstream words in a small FIFO and shifts them
// into 1..32 parallel configuration chains on a divided prog_clk.
module wb_fpga_config_loader #(
  parameter int unsigned NUM_CHAINS = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [31:0] ADR_BASE   = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  prog_clk,
  output logic [NUM_CHAINS-1:0] ccff_head,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  prog_done,
  output logic                  irq
);

  localparam int unsigned W  = 32 / NUM_CHAINS;
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  state_t                state_q;
  logic                  ack_q;
  logic [31:0]           dat_q;
  logic                  en_q;
  logic                  ovf_q;
  logic                  done_q;
  logic                  prog_done_q;
  logic                  prog_clk_q;
  logic [NUM_CHAINS-1:0] head_q;
  logic [31:0]           word_q;
  logic [31:0]           remaining_q;
  logic [31:0]           tail_q;
  logic [IW-1:0]         idx_q;
  logic [DW-1:0]         div_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         cnt_q;
  logic [31:0]           mem_q [0:FIFO_DEPTH-1];

  logic                  wb_hit;
  logic                  wb_acc;
  logic [2:0]            reg_idx;
  logic                  wr_ctrl;
  logic                  clr;
  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic                  bitcnt_wr;
  logic                  status_rd;
  logic                  full;
  logic                  empty;
  logic                  busy;
  logic                  div_end;
  logic [7:0]            cnt8;
  logic [31:0]           status_d;
  logic [31:0]           rdata_d;
  logic [31:0]           fifo_rdata;
  logic [IW-1:0]         idx_d;
  logic [NUM_CHAINS-1:0] head_d;
  logic                  unused_ok;

  // Decode on the upper address bits; the low word-offset field picks the register.
  assign wb_hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == ADR_BASE[31:5]);
  assign wb_acc    = wb_hit & ~ack_q;
  assign reg_idx   = wbs_adr_i[4:2];
  assign wr_ctrl   = wb_acc & wbs_we_i & (reg_idx == 3'd0);
  assign clr       = wr_ctrl & wbs_dat_i[1];
  assign push_req  = wb_acc & wbs_we_i & (reg_idx == 3'd2);
  assign bitcnt_wr = wb_acc & wbs_we_i & (reg_idx == 3'd3);
  assign status_rd = wb_acc & ~wbs_we_i & (reg_idx == 3'd1);
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], ccff_tail};

  assign full       = (cnt_q == CW'(FIFO_DEPTH));
  assign empty      = (cnt_q == '0);
  assign push       = push_req & ~full;
  assign pop        = (state_q == S_LOAD) & en_q & ~empty & ~clr;
  assign fifo_rdata = mem_q[rd_ptr_q];
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign div_end    = (div_q == DW'(CLK_DIV - 1));
  assign cnt8       = 8'(cnt_q);
  assign status_d   = {16'h0000, cnt8, 3'b000, ovf_q, done_q, empty, full, busy};

  // Next shift slice of the current word: shift i drives chain c with bit i*NUM_CHAINS+c.
  assign idx_d  = idx_q + IW'(1);
  assign head_d = NUM_CHAINS'(word_q >> (32'(idx_d) * NUM_CHAINS));

  always_comb begin
    rdata_d = '0;
    case (reg_idx)
      3'd0:    rdata_d = {31'b0, en_q};
      3'd1:    rdata_d = status_d;
      3'd3:    rdata_d = remaining_q;
      3'd4:    rdata_d = tail_q;
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      en_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ack_q <= wb_acc;
      dat_q <= (wb_acc && !wbs_we_i) ? rdata_d : 32'h0;
      if (wr_ctrl) en_q <= wbs_dat_i[0];
      if (clr || status_rd) ovf_q <= 1'b0;
      else if (push_req && full) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wbs_dat_i;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      prog_done_q <= 1'b0;
      prog_clk_q  <= 1'b0;
      head_q      <= '0;
      word_q      <= '0;
      remaining_q <= '0;
      tail_q      <= '0;
      idx_q       <= '0;
      div_q       <= '0;
    end else if (clr) begin
      // TAIL deliberately survives a clear so a partial readback stays visible.
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      prog_done_q <= 1'b0;
      prog_clk_q  <= 1'b0;
      head_q      <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      div_q       <= '0;
    end else begin
      if (status_rd) done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bitcnt_wr) remaining_q <= wbs_dat_i;
          else if (en_q && remaining_q != 32'd0) state_q <= S_LOAD;
        end
        S_LOAD: begin
          if (pop) begin
            word_q  <= fifo_rdata;
            head_q  <= fifo_rdata[NUM_CHAINS-1:0];
            idx_q   <= '0;
            div_q   <= '0;
            state_q <= S_LO;
          end
        end
        S_LO: begin
          // Clearing EN parks the shifter here with prog_clk low until EN returns.
          if (en_q) begin
            if (div_end) begin
              div_q       <= '0;
              prog_clk_q  <= 1'b1;
              remaining_q <= remaining_q - 32'd1;
              tail_q      <= {tail_q[30:0], ccff_tail[0]};
              state_q     <= S_HI;
            end else begin
              div_q <= div_q + DW'(1);
            end
          end
        end
        S_HI: begin
          if (div_end) begin
            div_q      <= '0;
            prog_clk_q <= 1'b0;
            if (remaining_q == 32'd0) begin
              done_q      <= 1'b1;
              prog_done_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (idx_q == IW'(W - 1)) begin
              state_q <= S_LOAD;
            end else begin
              idx_q   <= idx_d;
              head_q  <= head_d;
              state_q <= S_LO;
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        S_DONE: begin
          if (bitcnt_wr) begin
            remaining_q <= wbs_dat_i;
            prog_done_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign prog_clk  = prog_clk_q;
  assign ccff_head = head_q;
  assign prog_done = prog_done_q;
  assign irq       = done_q;

endmodule

// File: tb/tb_wb_fpga_config_loader.sv
// Scoreboard bench: one single-chain loader and one four-chain loader share the bus.
`timescale 1ns/1ps
module tb_wb_fpga_config_loader;

  localparam logic [31:0] A_CTRL   = 32'h3000_0000;
  localparam logic [31:0] A_STATUS = 32'h3000_0004;
  localparam logic [31:0] A_DATA   = 32'h3000_0008;
  localparam logic [31:0] A_BITCNT = 32'h3000_000C;
  localparam logic [31:0] A_TAIL   = 32'h3000_0010;
  localparam logic [31:0] B_CTRL   = 32'h3000_0100;
  localparam logic [31:0] B_STATUS = 32'h3000_0104;
  localparam logic [31:0] B_DATA   = 32'h3000_0108;
  localparam logic [31:0] B_BITCNT = 32'h3000_010C;
  localparam logic [31:0] B_TAIL   = 32'h3000_0110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;

  logic        ack_a, ack_b, ack_any;
  logic [31:0] dat_a, dat_b, dat_any;
  logic        pclk_a, pclk_b, pdone_a, pdone_b, irq_a, irq_b;
  logic [0:0]  head_a;
  logic [3:0]  head_b;

  always #5 clk = ~clk;

  assign ack_any = ack_a | ack_b;
  assign dat_any = dat_a | dat_b;

  wb_fpga_config_loader #(.NUM_CHAINS(1), .FIFO_DEPTH(4), .CLK_DIV(2), .ADR_BASE(32'h3000_0000)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_a), .wbs_dat_o(dat_a),
    .prog_clk(pclk_a), .ccff_head(head_a), .ccff_tail(head_a), .prog_done(pdone_a), .irq(irq_a)
  );

  wb_fpga_config_loader #(.NUM_CHAINS(4), .FIFO_DEPTH(4), .CLK_DIV(1), .ADR_BASE(32'h3000_0100)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_b), .wbs_dat_o(dat_b),
    .prog_clk(pclk_b), .ccff_head(head_b), .ccff_tail(head_b), .prog_done(pdone_b), .irq(irq_b)
  );

  typedef struct { logic [31:0] val; string name; } rd_t;
  typedef struct { logic [3:0] head; int gap; } sh_t;

  rd_t rd_q[$];
  sh_t sh_a[$];
  sh_t sh_b[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int last_a   = 0;
  int last_b   = 0;
  logic pa_prev = 1'b0;
  logic pb_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_n++;

  // Monitor: read acks and rising prog_clk edges are popped against the queues.
  always @(negedge clk) begin
    rd_t r;
    sh_t s;
    if (!rst && ack_any && !we) begin
      if (rd_q.size() == 0) check("unexpected_read_ack", {31'b0, ack_any}, 32'd0);
      else begin
        r = rd_q.pop_front();
        check(r.name, dat_any, r.val);
      end
    end
    if (pclk_a && !pa_prev) begin
      if (sh_a.size() == 0) check("unexpected_pulse_a", {31'b0, pclk_a}, 32'd0);
      else begin
        s = sh_a.pop_front();
        check("head_a", {31'b0, head_a}, {28'b0, s.head});
        if (s.gap != 0) check("period_a", 32'(cyc_n - last_a), 32'(s.gap));
      end
      last_a = cyc_n;
    end
    if (pclk_b && !pb_prev) begin
      if (sh_b.size() == 0) check("unexpected_pulse_b", {31'b0, pclk_b}, 32'd0);
      else begin
        s = sh_b.pop_front();
        check("head_b", {28'b0, head_b}, {28'b0, s.head});
        if (s.gap != 0) check("period_b", 32'(cyc_n - last_b), 32'(s.gap));
      end
      last_b = cyc_n;
    end
    pa_prev = pclk_a;
    pb_prev = pclk_b;
  end

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, output logic ok);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack_any) begin ok = 1'b1; break; end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic ok;
    xfer(a, 1'b1, d, ok);
    check("write_ack", {31'b0, ok}, 32'd1);
    $display("WR adr=0x%08h dat=0x%08h", a, d);
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] e, input string n);
    logic ok;
    rd_t r;
    r.val = e; r.name = n;
    rd_q.push_back(r);
    xfer(a, 1'b0, 32'h0, ok);
    if (!ok) void'(rd_q.pop_back());
    check({n, "_ack"}, {31'b0, ok}, 32'd1);
    $display("RD %s adr=0x%08h expected=0x%08h", n, a, e);
  endtask

  task automatic push_a(input logic [31:0] w, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      sh_t s;
      s.head = {3'b000, w[i]};
      s.gap  = (i == 0) ? 0 : gap;
      sh_a.push_back(s);
    end
  endtask

  task automatic push_b(input logic [3:0] h, input int gap);
    sh_t s;
    s.head = h;
    s.gap  = gap;
    sh_b.push_back(s);
  endtask

  task automatic wait_done(input bit which_b, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (which_b ? pdone_b : pdone_a) break;
      @(posedge clk); #1;
    end
    check(which_b ? "done_b_wait" : "done_a_wait", {31'b0, which_b ? pdone_b : pdone_a}, 32'd1);
  endtask

  task automatic wait_sh_a(input int left, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (sh_a.size() <= left) break;
      @(posedge clk); #1;
    end
    check("shift_a_wait", {31'b0, sh_a.size() <= left}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int k;
    logic [31:0] t;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    wb_read(A_STATUS, 32'h0000_0004, "a_status_reset");
    wb_read(A_CTRL,   32'h0,         "a_ctrl_reset");
    wb_read(A_BITCNT, 32'h0,         "a_bitcnt_reset");
    wb_read(A_TAIL,   32'h0,         "a_tail_reset");
    wb_read(B_STATUS, 32'h0000_0004, "b_status_reset");
    check("a_irq_reset", {31'b0, irq_a}, 32'd0);
    check("a_prog_done_reset", {31'b0, pdone_a}, 32'd0);

    // Address miss: no ack, data bus stays 0
    xfer(32'h3000_0200, 1'b0, 32'h0, ok);
    check("miss_no_ack", {31'b0, ok}, 32'd0);
    check("miss_dat", dat_any, 32'h0);

    // Single chain, 8 bits of 0xA5, period 4
    wb_write(A_BITCNT, 32'd8);
    wb_write(A_DATA, 32'h0000_00A5);
    wb_read(A_STATUS, 32'h0000_0100, "a_status_one_word");
    push_a(32'h0000_00A5, 8, 4);
    wb_write(A_CTRL, 32'h1);
    wait_done(1'b0, 200);
    check("a_irq_done", {31'b0, irq_a}, 32'd1);
    wb_read(A_BITCNT, 32'h0, "a_bitcnt_after");
    wb_read(A_TAIL, 32'h0000_00A5, "a_tail_a5");
    wb_read(A_STATUS, 32'h0000_000C, "a_status_done");
    wb_read(A_STATUS, 32'h0000_0004, "a_status_done_cleared");
    check("a_irq_cleared", {31'b0, irq_a}, 32'd0);
    check("a_prog_done_held", {31'b0, pdone_a}, 32'd1);
    wb_write(A_BITCNT, 32'd0);
    repeat (10) @(posedge clk); #1;
    wb_read(A_STATUS, 32'h0000_0004, "a_status_en_bitcnt0");
    check("a_prog_done_released", {31'b0, pdone_a}, 32'd0);

    // Overflow with EN=0
    wb_write(A_CTRL, 32'h0);
    for (int i = 1; i <= 5; i++) wb_write(A_DATA, 32'(i));
    wb_read(A_STATUS, 32'h0000_0412, "a_status_ovf");
    wb_read(A_STATUS, 32'h0000_0402, "a_status_ovf_cleared");
    wb_write(A_CTRL, 32'h2);
    wb_read(A_STATUS, 32'h0000_0004, "a_status_after_clr");

    // 64 bits with one word: stall after 32 pulses, then resume
    wb_write(A_BITCNT, 32'd64);
    wb_write(A_DATA, 32'h1234_5678);
    push_a(32'h1234_5678, 32, 4);
    wb_write(A_CTRL, 32'h1);
    wait_sh_a(0, 400);
    repeat (12) @(posedge clk); #1;
    check("a_stall_prog_clk", {31'b0, pclk_a}, 32'd0);
    wb_read(A_STATUS, 32'h0000_0005, "a_status_stall");
    wb_write(A_BITCNT, 32'd5);
    wb_read(A_BITCNT, 32'd32, "a_bitcnt_busy_ignored");
    push_a(32'h0000_00F0, 32, 4);
    wb_write(A_DATA, 32'h0000_00F0);
    wait_done(1'b0, 400);
    wb_read(A_TAIL, 32'h0F00_0000, "a_tail_second_word");
    wb_read(A_STATUS, 32'h0000_000C, "a_status_done_64");
    wb_read(A_BITCNT, 32'h0, "a_bitcnt_done_64");

    // Four chains, CLK_DIV=1: packing and mid-word exhaustion
    wb_write(B_BITCNT, 32'd8);
    wb_write(B_DATA, 32'h0000_00F1);
    push_b(4'b0001, 0);
    push_b(4'b1111, 2);
    for (int i = 0; i < 6; i++) push_b(4'b0000, 2);
    wb_write(B_CTRL, 32'h1);
    wait_done(1'b1, 200);
    wb_read(B_STATUS, 32'h0000_000C, "b_status_done");
    wb_write(B_BITCNT, 32'd3);
    push_b(4'h1, 0);
    push_b(4'h2, 2);
    push_b(4'h3, 2);
    wb_write(B_DATA, 32'h0000_0321);
    wait_done(1'b1, 200);
    wb_write(B_BITCNT, 32'd1);
    push_b(4'h7, 0);
    wb_write(B_DATA, 32'hFFFF_FFF7);
    wait_done(1'b1, 200);
    wb_read(B_TAIL, 32'h0000_0C0B, "b_tail");
    wb_read(B_STATUS, 32'h0000_000C, "b_status_final");

    // Clear mid-shift
    wb_write(A_BITCNT, 32'd32);
    push_a(32'hFFFF_FFFF, 32, 4);
    wb_write(A_DATA, 32'hFFFF_FFFF);
    wait_sh_a(29, 200);
    wb_write(A_CTRL, 32'h2);
    k = 32 - sh_a.size();
    sh_a.delete();
    check("a_clr_prog_clk", {31'b0, pclk_a}, 32'd0);
    check("a_clr_head", {31'b0, head_a}, 32'd0);
    wb_read(A_STATUS, 32'h0000_0004, "a_status_mid_clr");
    t = (32'h0F00_0000 << k) | ((32'h1 << k) - 32'h1);
    wb_read(A_TAIL, t, "a_tail_kept");
    repeat (20) @(posedge clk); #1;

    // Reset mid-shift
    wb_write(A_BITCNT, 32'd32);
    push_a(32'hFFFF_FFFF, 32, 4);
    wb_write(A_DATA, 32'hFFFF_FFFF);
    wb_write(A_CTRL, 32'h1);
    wait_sh_a(30, 200);
    for (int i = 0; i < 8; i++) begin
      if (pclk_a) break;
      @(posedge clk); #1;
    end
    check("a_high_before_reset", {31'b0, pclk_a}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check("rst_prog_clk", {31'b0, pclk_a}, 32'd0);
    check("rst_head", {31'b0, head_a}, 32'd0);
    check("rst_ack", {31'b0, ack_any}, 32'd0);
    check("rst_irq", {31'b0, irq_a}, 32'd0);
    check("rst_prog_done", {31'b0, pdone_a}, 32'd0);
    sh_a.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    wb_read(A_STATUS, 32'h0000_0004, "a_status_after_reset");
    wb_read(A_TAIL, 32'h0, "a_tail_after_reset");
    wb_read(A_CTRL, 32'h0, "a_ctrl_after_reset");
    repeat (10) @(posedge clk); #1;

    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("shift_a_drained", 32'(sh_a.size()), 32'd0);
    check("shift_b_drained", 32'(sh_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
